// File: rtl/key_filter_multi.sv
// N-channel push-button conditioner: per-key 2-flop synchroniser, press/release
// debounce, long-press detection and auto-repeat, all outputs registered.
module key_filter_multi #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILT_DN = 2'd1,
    ST_DOWN    = 2'd2,
    ST_FILT_UP = 2'd3
  } state_e;

  localparam logic             IDLE_LVL  = (ACTIVE_LOW != 0);
  localparam logic             LONG_EN   = (LONG_CYCLES != 0);
  localparam logic             REP_EN    = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    logic             sync1_q, sync2_q;
    logic             pressed;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             long_done_q, long_done_d;
    logic             ks_q, ks_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;

    // Synchronised sample normalised so that 1 always means pressed
    assign pressed = sync2_q ^ IDLE_LVL;

    // State, counters and output registers; sync flops reset to idle level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q     <= IDLE_LVL;
        sync2_q     <= IDLE_LVL;
        state_q     <= ST_IDLE;
        dcnt_q      <= '0;
        hcnt_q      <= '0;
        long_done_q <= 1'b0;
        ks_q        <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        long_q      <= 1'b0;
        rep_q       <= 1'b0;
      end else begin
        sync1_q     <= key_in[g];
        sync2_q     <= sync1_q;
        state_q     <= state_d;
        dcnt_q      <= dcnt_d;
        hcnt_q      <= hcnt_d;
        long_done_q <= long_done_d;
        ks_q        <= ks_d;
        press_q     <= press_d;
        rel_q       <= rel_d;
        long_q      <= long_d;
        rep_q       <= rep_d;
      end
    end

    // Debounce / hold FSM next-state and next-output logic
    always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      long_done_d = long_done_q;
      ks_d        = ks_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      long_d      = 1'b0;
      rep_d       = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            state_d = ST_FILT_DN;
            dcnt_d  = '0;
          end
        end

        ST_FILT_DN: begin
          if (!pressed) begin
            state_d = ST_IDLE;
          end else if (dcnt_q == DEB_LAST) begin
            state_d     = ST_DOWN;
            press_d     = 1'b1;
            ks_d        = 1'b1;
            hcnt_d      = '0;
            long_done_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + CNT_ONE;
          end
        end

        ST_DOWN: begin
          if (!pressed) begin
            state_d = ST_FILT_UP;
            dcnt_d  = '0;
          end else if (!long_done_q && LONG_EN && (hcnt_q == LONG_LAST)) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            hcnt_d      = '0;
          end else if (long_done_q && REP_EN && (hcnt_q == REP_LAST)) begin
            rep_d  = 1'b1;
            hcnt_d = '0;
          end else if (hcnt_q != '1) begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
        end

        ST_FILT_UP: begin
          // Hold counter stays frozen here and resumes if the key bounces back
          if (pressed) begin
            state_d = ST_DOWN;
          end else if (dcnt_q == DEB_LAST) begin
            state_d     = ST_IDLE;
            rel_d       = 1'b1;
            ks_d        = 1'b0;
            hcnt_d      = '0;
            long_done_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d     = ST_IDLE;
          dcnt_d      = '0;
          hcnt_d      = '0;
          long_done_d = 1'b0;
          ks_d        = 1'b0;
        end
      endcase
    end

    assign key_state[g]     = ks_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = rel_q;
    assign long_pulse[g]    = long_q;
    assign repeat_pulse[g]  = rep_q;
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Randomised bench for key_filter_multi: two instances (active-low with long/repeat,
// active-high with long disabled) checked every cycle against a run-length reference.
module tb_key_filter_multi;

  localparam int unsigned NK = 2;
  localparam int          D  = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_a = 2'b11;
  logic [NK-1:0] key_b = 2'b00;

  logic [NK-1:0] ks_a, pr_a, rl_a, lg_a, rp_a;
  logic [NK-1:0] ks_b, pr_b, rl_b, lg_b, rp_b;

  always #5 clk = ~clk;

  key_filter_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(32), .REPEAT_CYCLES(16), .CNT_W(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .key_in(key_a),
    .key_state(ks_a), .press_pulse(pr_a), .release_pulse(rl_a),
    .long_pulse(lg_a), .repeat_pulse(rp_a)
  );

  key_filter_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(0), .REPEAT_CYCLES(16), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .key_in(key_b),
    .key_state(ks_b), .press_pulse(pr_b), .release_pulse(rl_b),
    .long_pulse(lg_b), .repeat_pulse(rp_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference: a key toggles its accepted level after D+1 consecutive differing
  // samples; hold time counts only samples taken while settled in the pressed level.
  bit            h1   [2][NK];
  bit            h2   [2][NK];
  bit            acc  [2][NK];
  int            run  [2][NK];
  int            hold [2][NK];
  logic [NK-1:0] e_ks [2];
  logic [NK-1:0] e_pr [2];
  logic [NK-1:0] e_rl [2];
  logic [NK-1:0] e_lg [2];
  logic [NK-1:0] e_rp [2];
  int            long_cfg [2] = '{32, 0};
  int            rep_cfg  [2] = '{16, 16};

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      e_ks[d] = '0; e_pr[d] = '0; e_rl[d] = '0; e_lg[d] = '0; e_rp[d] = '0;
      for (int k = 0; k < NK; k++) begin
        h1[d][k] = 1'b0; h2[d][k] = 1'b0; acc[d][k] = 1'b0;
        run[d][k] = 0; hold[d][k] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      e_pr[d] = '0; e_rl[d] = '0; e_lg[d] = '0; e_rp[d] = '0;
      for (int k = 0; k < NK; k++) begin
        bit p;
        bit settled;
        p        = h2[d][k];
        h2[d][k] = h1[d][k];
        h1[d][k] = (d == 0) ? ~key_a[k] : key_b[k];
        settled  = acc[d][k] && (run[d][k] == 0);
        if (p != acc[d][k]) begin
          run[d][k]++;
          if (run[d][k] == D + 1) begin
            acc[d][k]  = p;
            run[d][k]  = 0;
            hold[d][k] = 0;
            e_ks[d][k] = p;
            if (p) e_pr[d][k] = 1'b1;
            else   e_rl[d][k] = 1'b1;
          end
        end else begin
          run[d][k] = 0;
          if (settled && long_cfg[d] != 0) begin
            hold[d][k]++;
            if (hold[d][k] == long_cfg[d])
              e_lg[d][k] = 1'b1;
            else if (rep_cfg[d] != 0 && hold[d][k] > long_cfg[d] &&
                     ((hold[d][k] - long_cfg[d]) % rep_cfg[d]) == 0)
              e_rp[d][k] = 1'b1;
          end
        end
      end
    end
  endtask

  // Model advances by the posedge just passed, then every output is compared
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      else        model_step();
      check("a.key_state", 32'(ks_a), 32'(e_ks[0]));
      check("a.press",     32'(pr_a), 32'(e_pr[0]));
      check("a.release",   32'(rl_a), 32'(e_rl[0]));
      check("a.long",      32'(lg_a), 32'(e_lg[0]));
      check("a.repeat",    32'(rp_a), 32'(e_rp[0]));
      check("b.key_state", 32'(ks_b), 32'(e_ks[1]));
      check("b.press",     32'(pr_b), 32'(e_pr[1]));
      check("b.release",   32'(rl_b), 32'(e_rl[1]));
      check("b.long",      32'(lg_b), 32'(e_lg[1]));
      check("b.repeat",    32'(rp_b), 32'(e_rp[1]));
    end
  end

  task automatic drive(input logic [NK-1:0] va, input logic [NK-1:0] vb, input int n);
    key_a = va;
    key_b = vb;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a"}, 32'({ks_a, pr_a, rl_a, lg_a, rp_a}), 32'd0);
    check({tag, ".b"}, 32'({ks_b, pr_b, rl_b, lg_b, rp_b}), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Clean press held long enough to see it accepted
    drive(2'b10, 2'b00, 40);
    drive(2'b11, 2'b00, 20);
    // Short bounces, then a real press
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 2'b00, 5);
      drive(2'b11, 2'b00, 5);
    end
    drive(2'b10, 2'b00, 20);
    // Release glitch while held, then clean release
    drive(2'b11, 2'b00, 3);
    drive(2'b10, 2'b00, 10);
    drive(2'b11, 2'b00, 20);
    // Long hold through long press and several repeats
    drive(2'b10, 2'b00, 140);
    drive(2'b11, 2'b00, 30);
    // Simultaneous press on both keys
    drive(2'b00, 2'b00, 20);
    drive(2'b11, 2'b00, 20);
    // Key 0 held, key 1 mid-filter, then asynchronous reset
    drive(2'b10, 2'b00, 20);
    drive(2'b00, 2'b00, 6);
    check("pre_reset.ks_a", 32'(ks_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    key_a = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 20);
    // Active-high instance with long press disabled
    drive(2'b11, 2'b10, 100);
    drive(2'b11, 2'b00, 20);

    // Random phase: mix of bounce-length and hold-length segments
    for (int i = 0; i < 120; i++) begin
      logic [NK-1:0] va;
      logic [NK-1:0] vb;
      int            n;
      va = NK'($urandom);
      vb = NK'($urandom);
      n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 90))
                                       : int'($urandom_range(1, 12));
      drive(va, vb, n);
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
      end
    end
    drive(2'b11, 2'b00, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_filter_multi.md
Name: key_filter_multi

Overview:
- Parametrised N-channel push-button conditioner; the next generation of the single-key debouncer.
- Per channel: 2-flop synchroniser, press/release debounce FSM, long-press detection and auto-repeat.
- Sits between board key pins and the alarm/clock control FSMs.
- Outputs one-cycle event pulses plus a debounced level per key.

Parameters:
NUM_KEYS, 4, number of independent key channels
ACTIVE_LOW, 1, 1: key pressed = input 0; 0: pressed = input 1
DEBOUNCE_CYCLES, 1_000_000, stable cycles required to accept a press or release (20 ms @ 50 MHz); must be >= 2
LONG_CYCLES, 50_000_000, cycles held in DOWN before long_pulse; 0 disables long-press and repeat
REPEAT_CYCLES, 10_000_000, auto-repeat period after long_pulse; 0 disables repeat
CNT_W, 26, counter width; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)

Ports:
clk, input, 1, system clock
rst_n, input, 1, asynchronous active-low reset
key_in, input, NUM_KEYS, raw asynchronous key pins
key_state, output, NUM_KEYS, debounced level, 1 = pressed (polarity-normalised)
press_pulse, output, NUM_KEYS, 1-cycle pulse on accepted press
release_pulse, output, NUM_KEYS, 1-cycle pulse on accepted release
long_pulse, output, NUM_KEYS, 1-cycle pulse when held LONG_CYCLES
repeat_pulse, output, NUM_KEYS, 1-cycle pulse every REPEAT_CYCLES after long_pulse while held

Behaviour:
- Reset (async, rst_n low): all outputs 0; FSMs in IDLE; counters 0; long_done 0; synchroniser flops = idle level (1 if ACTIVE_LOW). This guarantees no false edge after reset release.
- Reset asserted mid-operation aborts every channel immediately. No release_pulse is generated.
- Channels are fully independent. Simultaneous events on several channels each pulse in the same cycle.
- p = synchronised, polarity-normalised sample (1 = pressed). All outputs are registered.
- Per-channel FSM states: IDLE, FILT_DN, DOWN, FILT_UP. Each channel has a debounce counter dcnt and a hold counter hcnt.
- IDLE:
  - p=1 -> FILT_DN, dcnt<=0.
- FILT_DN:
  - p=0 -> IDLE, no pulse.
  - p=1 and dcnt==DEBOUNCE_CYCLES-1 -> DOWN: press_pulse<=1, key_state<=1, hcnt<=0, long_done<=0.
  - Otherwise dcnt++.
- Press latency: if key_in changes between edges, press_pulse/key_state rise after rising edge DEBOUNCE_CYCLES+3 counted from that change. Edges 1-2 are sync, edge 3 enters FILT_DN.
- DOWN:
  - p=0 -> FILT_UP, dcnt<=0; hcnt frozen.
  - Else, if long_done=0 and LONG_CYCLES!=0 and hcnt==LONG_CYCLES-1: long_pulse<=1, long_done<=1, hcnt<=0.
  - Else, if long_done=1 and REPEAT_CYCLES!=0 and hcnt==REPEAT_CYCLES-1: repeat_pulse<=1, hcnt<=0.
  - Otherwise hcnt++, saturating at all-ones.
- FILT_UP:
  - p=1 -> DOWN; hcnt resumes from its frozen value.
  - p=0 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE: release_pulse<=1, key_state<=0, hcnt<=0, long_done<=0.
  - Otherwise dcnt++.
  - No long or repeat pulses are issued in FILT_UP.
- Release latency equals press latency (DEBOUNCE_CYCLES+3 edges).
- Pulse sequencing:
  - Exactly one press_pulse and at most one release_pulse per accepted press; release never occurs without a prior press.
  - long_pulse at most once per press.
  - press_pulse and release_pulse never both high on one channel.
- Illegal/unreachable state encoding -> IDLE with all channel outputs 0.

Test Plan:
(NUM_KEYS=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=16)
1. key_in[0] driven 1->0 mid-cycle and held 40 cycles -> press_pulse[0] high for exactly 1 cycle after edge 11; key_state[0]=1 from then on; channel 1 outputs stay 0.
2. key_in[0] low 5 cycles then high (bounce) -> no pulse, key_state[0] stays 0. Repeat 3 times, then hold low -> single press_pulse 11 edges after the final low edge.
3. Held key gets a 3-cycle high glitch -> no release_pulse, key_state[0] stays 1. Clean release -> release_pulse[0] 11 edges later, key_state[0]=0.
4. Hold 120 cycles past press_pulse -> long_pulse 32 cycles after press_pulse; repeat_pulse at +48, +64, +80, +96, +112; on release, release_pulse and no further repeat pulses.
5. Both keys pressed on the same cycle -> press_pulse=2'b11 in one cycle. Assert rst_n low during key 1 FILT_DN -> all outputs 0 at once; after deassert with keys high, no pulses.
6. ACTIVE_LOW=0, key_in[1] 0->1 held -> press_pulse[1] after edge 11. LONG_CYCLES=0 -> no long_pulse or repeat_pulse ever.
